// File: rtl/vend_sequencer.sv
// vend_sequencer: conditions coin/button inputs into pending events, grants them
// in fixed priority and executes each as a digit-serial BCD add/subtract on the
// money register, updating stock, LEDs and the display code.
module vend_sequencer #(
  parameter int MSG_HOLD = 100_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halfyuan,
  input  logic        oneyuan,
  input  logic        sell_cola,
  input  logic        sell_tea,
  input  logic        sell_milk,
  input  logic        supply,
  input  logic        coin_return,
  output logic [15:0] money_bcd,
  output logic [15:0] stock,
  output logic [15:0] disp_code,
  output logic        cola_led,
  output logic        tea_led,
  output logic        milk_led,
  output logic        busy,
  output logic        refund_pulse,
  output logic [15:0] refund_amount,
  output logic        coin_reject
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_CALC, S_COMMIT} state_t;
  // Encoding doubles as the pending-bit index; lower index = higher priority.
  typedef enum logic [2:0] {
    OP_RET, OP_SUP, OP_ONE, OP_HALF, OP_COLA, OP_TEA, OP_MILK
  } op_t;

  localparam logic [15:0] STOCK_FULL = 16'hC555;

  logic [6:0]  w_raw;
  logic [6:0]  r_s1, r_s2, r_s3, r_evt;
  logic [6:0]  r_pend;
  logic [2:0]  w_gnt_idx;
  logic [6:0]  w_gnt_mask;
  logic        w_any;

  state_t      r_state;
  op_t         r_op;
  logic [15:0] r_money, r_stock, r_temp, r_operand, r_msg, r_refund_amt;
  logic [1:0]  r_digit;
  logic        r_carry;
  logic [2:0]  r_leds;
  logic        r_soldout;
  logic [26:0] r_timer;
  logic        r_busy, r_refund_pulse, r_coin_reject;

  logic        w_is_sell;
  logic [1:0]  w_pidx;
  logic [3:0]  w_pnib;
  logic [15:0] w_price, w_coin_amt;
  logic [3:0]  w_dsh;
  logic [3:0]  w_a, w_b, w_dig;
  logic [4:0]  w_sum, w_dif;
  logic        w_cout;

  assign w_raw = {sell_milk, sell_tea, sell_cola, halfyuan, oneyuan, supply, coin_return};

  // 2-FF synchronizer, edge history and registered one-cycle event pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_s3  <= '0;
      r_evt <= '0;
    end else begin
      r_s1  <= w_raw;
      r_s2  <= r_s1;
      r_s3  <= r_s2;
      r_evt <= r_s2 & ~r_s3;
    end
  end

  // Fixed-priority pick of the lowest-index pending bit
  always_comb begin
    w_gnt_idx = 3'd0;
    for (int i = 6; i >= 0; i--)
      if (r_pend[i]) w_gnt_idx = 3'(i);
    w_gnt_mask = 7'd1 << w_gnt_idx;
    w_any      = |r_pend;
  end

  // Pending bits: events set, grant clears; a same-cycle new event still lands
  always_ff @(posedge clk) begin
    if (!rst_n) r_pend <= '0;
    else        r_pend <= (r_pend & ~((r_state == S_IDLE && w_any) ? w_gnt_mask : 7'd0)) | r_evt;
  end

  // Operation decode: product index, stock nibble, price and coin operand
  always_comb begin
    w_is_sell  = (r_op == OP_COLA) || (r_op == OP_TEA) || (r_op == OP_MILK);
    w_pidx     = (r_op == OP_COLA) ? 2'd0 : (r_op == OP_TEA) ? 2'd1 : 2'd2;
    w_pnib     = r_stock[{w_pidx, 2'b00} +: 4];
    w_price    = (r_op == OP_COLA) ? 16'h0020 : (r_op == OP_TEA) ? 16'h0030 : 16'h0035;
    w_coin_amt = (r_op == OP_ONE) ? 16'h0010 : 16'h0005;
  end

  // One BCD digit of add (with decimal adjust) or subtract (with borrow adjust)
  always_comb begin
    w_dsh  = {r_digit, 2'b00};
    w_a    = r_money[w_dsh +: 4];
    w_b    = r_operand[w_dsh +: 4];
    w_sum  = {1'b0, w_a} + {1'b0, w_b} + {4'd0, r_carry};
    w_dif  = {1'b0, w_a} - {1'b0, w_b} - {4'd0, r_carry};
    w_dig  = 4'd0;
    w_cout = 1'b0;
    if (w_is_sell) begin
      w_dig  = w_dif[4] ? (w_dif[3:0] - 4'd6) : w_dif[3:0];
      w_cout = w_dif[4];
    end else begin
      w_dig  = (w_sum > 5'd9) ? (w_sum[3:0] + 4'd6) : w_sum[3:0];
      w_cout = (w_sum > 5'd9);
    end
  end

  // Transaction FSM with registered results, strobes and message timer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_op           <= OP_RET;
      r_money        <= '0;
      r_stock        <= STOCK_FULL;
      r_temp         <= '0;
      r_operand      <= '0;
      r_msg          <= '0;
      r_refund_amt   <= '0;
      r_digit        <= '0;
      r_carry        <= 1'b0;
      r_leds         <= '0;
      r_soldout      <= 1'b0;
      r_timer        <= '0;
      r_busy         <= 1'b0;
      r_refund_pulse <= 1'b0;
      r_coin_reject  <= 1'b0;
    end else begin
      r_refund_pulse <= 1'b0;
      r_coin_reject  <= 1'b0;
      if (r_timer != 27'd0) r_timer <= r_timer - 27'd1;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_op      <= op_t'(w_gnt_idx);
            r_leds    <= '0;
            r_timer   <= '0;
            r_soldout <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (r_op == OP_RET || r_op == OP_SUP) begin
            r_state <= S_COMMIT;
          end else if (w_is_sell && w_pnib == 4'd0) begin
            r_soldout <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else if (w_is_sell && r_money < w_price) begin
            r_msg   <= {8'hCC, w_price[7:0]};
            r_timer <= 27'(MSG_HOLD);
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_operand <= w_is_sell ? w_price : w_coin_amt;
            r_digit   <= 2'd0;
            r_carry   <= 1'b0;
            r_temp    <= '0;
            r_state   <= S_CALC;
          end
        end
        S_CALC: begin
          r_temp[w_dsh +: 4] <= w_dig;
          r_carry            <= w_cout;
          r_digit            <= r_digit + 2'd1;
          if (r_digit == 2'd3) r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          case (r_op)
            OP_RET: begin
              r_refund_amt   <= r_money;
              r_refund_pulse <= 1'b1;
              r_money        <= '0;
            end
            OP_SUP: r_stock <= STOCK_FULL;
            OP_ONE, OP_HALF: begin
              // carry out of the top digit means the credit would exceed 999.9
              if (r_carry) r_coin_reject <= 1'b1;
              else         r_money       <= r_temp;
            end
            default: begin
              r_money                       <= r_temp;
              r_stock[{w_pidx, 2'b00} +: 4] <= w_pnib - 4'd1;
              r_leds[w_pidx]                <= 1'b1;
            end
          endcase
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign money_bcd     = r_money;
  assign stock         = r_stock;
  assign disp_code     = r_soldout ? 16'hFFFF : ((r_timer != 27'd0) ? r_msg : r_money);
  assign cola_led      = r_leds[0];
  assign tea_led       = r_leds[1];
  assign milk_led      = r_leds[2];
  assign busy          = r_busy;
  assign refund_pulse  = r_refund_pulse;
  assign refund_amount = r_refund_amt;
  assign coin_reject   = r_coin_reject;

endmodule

// File: tb/tb_vend_sequencer.sv
// Bench for vend_sequencer: directed and random operations compared against a
// decimal-arithmetic model of credit, stock, LEDs, strobes and display.
module tb_vend_sequencer;

  localparam int HOLD = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  raw;  // {milk, tea, cola, half, one, supply, return}
  logic [15:0] money_bcd, stock, disp_code, refund_amount;
  logic        cola_led, tea_led, milk_led, busy, refund_pulse, coin_reject;

  vend_sequencer #(.MSG_HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n),
    .halfyuan(raw[3]), .oneyuan(raw[2]),
    .sell_cola(raw[4]), .sell_tea(raw[5]), .sell_milk(raw[6]),
    .supply(raw[1]), .coin_return(raw[0]),
    .money_bcd(money_bcd), .stock(stock), .disp_code(disp_code),
    .cola_led(cola_led), .tea_led(tea_led), .milk_led(milk_led),
    .busy(busy), .refund_pulse(refund_pulse), .refund_amount(refund_amount),
    .coin_reject(coin_reject)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  // Model state: credit in tenths of a yuan, stock counts per product
  int m_money;
  int m_stock[3];
  bit m_soldout;
  logic [2:0] m_led;
  int m_refamt;
  // Expected per-window observations
  int e_ref, e_rej, e_busy, e_msg;
  // Observed per-window counters
  int o_busy, o_ref, o_rej, o_msg;
  logic [15:0] o_first;

  localparam int OP_RET = 0, OP_SUP = 1, OP_ONE = 2, OP_HALF = 3,
                 OP_COLA = 4, OP_TEA = 5, OP_MILK = 6;

  function automatic logic [15:0] bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_money = 0; m_stock[0] = 5; m_stock[1] = 5; m_stock[2] = 5;
    m_soldout = 0; m_led = 3'b000; m_refamt = 0;
  endtask

  task automatic clear_exp();
    e_ref = 0; e_rej = 0; e_busy = 0; e_msg = 0;
  endtask

  // Apply one granted operation using plain decimal arithmetic
  task automatic model_op(input int op);
    int price[3] = '{20, 30, 35};
    int p;
    m_led = 3'b000;
    m_soldout = 0;
    case (op)
      OP_RET: begin e_ref++; e_busy += 2; m_refamt = m_money; m_money = 0; end
      OP_SUP: begin e_busy += 2; m_stock[0] = 5; m_stock[1] = 5; m_stock[2] = 5; end
      OP_ONE, OP_HALF: begin
        e_busy += 6;
        if (m_money + ((op == OP_ONE) ? 10 : 5) > 9999) e_rej++;
        else m_money += (op == OP_ONE) ? 10 : 5;
      end
      default: begin
        p = op - OP_COLA;
        if (m_stock[p] == 0) begin e_busy += 1; m_soldout = 1; end
        else if (m_money < price[p]) begin e_busy += 1; e_msg += HOLD; end
        else begin
          e_busy += 6; m_money -= price[p]; m_stock[p]--; m_led[p] = 1'b1;
        end
      end
    endcase
  endtask

  // Press the raw inputs in mask for 4 cycles, then observe for 'cycles'
  task automatic run(input logic [6:0] mask, input int cycles);
    logic [15:0] m0;
    o_busy = 0; o_ref = 0; o_rej = 0; o_msg = 0;
    m0 = money_bcd; o_first = money_bcd;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (busy) o_busy++;
      if (refund_pulse) o_ref++;
      if (coin_reject) o_rej++;
      if (disp_code[15:8] == 8'hCC) o_msg++;
      if (o_first == m0 && money_bcd != m0) o_first = money_bcd;
      if (i == 0) raw = mask;
      if (i == 4) raw = '0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".money"}, money_bcd, bcd(m_money));
    chk({tag, ".stock"}, stock, {4'hC, 4'(m_stock[2]), 4'(m_stock[1]), 4'(m_stock[0])});
    chk({tag, ".disp"}, disp_code, m_soldout ? 16'hFFFF : bcd(m_money));
    chk({tag, ".leds"}, {milk_led, tea_led, cola_led}, m_led);
    chk({tag, ".refamt"}, refund_amount, bcd(m_refamt));
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".busycyc"}, o_busy, e_busy);
    chk({tag, ".refpulse"}, o_ref, e_ref);
    chk({tag, ".reject"}, o_rej, e_rej);
    chk({tag, ".msgcyc"}, o_msg, e_msg);
  endtask

  task automatic do_op(input int op, input string tag);
    clear_exp();
    run(7'd1 << op, 32);
    model_op(op);
    check_all(tag);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".money"}, money_bcd, 16'h0000);
    chk({tag, ".stock"}, stock, 16'hC555);
    chk({tag, ".disp"}, disp_code, 16'h0000);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".leds"}, {milk_led, tea_led, cola_led}, 3'b000);
    chk({tag, ".strobes"}, {refund_pulse, coin_reject}, 2'b00);
    chk({tag, ".refamt"}, refund_amount, 16'h0000);
  endtask

  initial begin
    int r, op, wait_n;
    raw = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;

    // Purchase: 1.0 + 1.0 + 0.5, then a cola
    do_op(OP_ONE, "coin1");
    do_op(OP_ONE, "coin2");
    do_op(OP_HALF, "half1");
    chk("purchase.money", money_bcd, 16'h0025);
    do_op(OP_COLA, "cola");
    chk("cola.money", money_bcd, 16'h0005);
    chk("cola.stock", stock, 16'hC554);
    chk("cola.led", cola_led, 1'b1);
    chk("cola.busy6", o_busy, 6);

    // Insufficient funds at 3.0 for milk
    do_op(OP_ONE, "c3"); do_op(OP_ONE, "c4"); do_op(OP_HALF, "h2");
    chk("insuf.pre", money_bcd, 16'h0030);
    do_op(OP_MILK, "insuf");
    // Repeat, with a half-yuan arriving while the message is showing
    clear_exp();
    o_busy = 0; o_msg = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (disp_code[15:8] == 8'hCC) begin
        o_msg++;
        chk("insuf2.code", disp_code, 16'hCC35);
      end
      if (i == 0) raw = 7'd1 << OP_MILK;
      if (i == 4) raw = '0;
      if (i == 10) raw = 7'd1 << OP_HALF;
      if (i == 14) raw = '0;
    end
    model_op(OP_MILK);
    model_op(OP_HALF);
    chk("insuf2.cut", (o_msg > 0) && (o_msg < HOLD), 1'b1);
    chk("insuf2.money", money_bcd, bcd(m_money));
    chk("insuf2.disp", disp_code, 16'h0035);

    // Sold out and restock
    do_op(OP_SUP, "sup1");
    for (int i = 0; i < 7; i++) do_op(OP_ONE, "fill");
    for (int i = 0; i < 5; i++) do_op(OP_COLA, "cola5");
    chk("soldout.nib", stock[3:0], 4'h0);
    do_op(OP_COLA, "cola6");
    chk("soldout.disp", disp_code, 16'hFFFF);
    do_op(OP_SUP, "sup2");
    chk("restock", stock, 16'hC555);

    // Simultaneous coin and tea at 2.0
    do_op(OP_RET, "ret0");
    do_op(OP_ONE, "s1"); do_op(OP_ONE, "s2");
    clear_exp();
    run((7'd1 << OP_ONE) | (7'd1 << OP_TEA), 48);
    model_op(OP_ONE);
    model_op(OP_TEA);
    check_all("simul");
    chk("simul.first", o_first, 16'h0030);
    chk("simul.stock", stock, 16'hC545);

    // Refund of 12.5
    do_op(OP_RET, "ret1");
    for (int i = 0; i < 12; i++) do_op(OP_ONE, "r");
    do_op(OP_HALF, "rh");
    do_op(OP_RET, "refund");
    chk("refund.amt", refund_amount, 16'h0125);

    // Fill to 999.5 then overflow
    for (int i = 0; i < 999; i++) begin
      clear_exp(); run(7'd1 << OP_ONE, 16); model_op(OP_ONE);
    end
    clear_exp(); run(7'd1 << OP_HALF, 16); model_op(OP_HALF);
    chk("fill.money", money_bcd, 16'h9995);
    do_op(OP_ONE, "ovf");
    chk("ovf.money", money_bcd, 16'h9995);
    chk("ovf.reject", o_rej, 1);

    // Random operations against the model
    do_op(OP_RET, "rret");
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 15);
      op = (r == 0) ? OP_RET : (r == 1) ? OP_SUP : (r <= 6) ? OP_ONE :
           (r <= 8) ? OP_HALF : (r <= 10) ? OP_COLA : (r <= 12) ? OP_TEA : OP_MILK;
      do_op(op, "rand");
    end

    // Reset while a coin add is in CALC
    do_op(OP_ONE, "pre_rst");
    raw = 7'd1 << OP_ONE;
    wait_n = 0;
    while (!busy && wait_n < 20) begin @(negedge clk); wait_n++; end
    chk("rst.busyseen", busy, 1'b1);
    @(negedge clk); @(negedge clk);
    raw = '0;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("midreset");
    rst_n = 1'b1;
    model_reset();
    repeat (12) @(negedge clk);
    check_reset("postreset");
    do_op(OP_HALF, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
